// File: rtl/multi_hit_controller.sv
// Multi-laser / multi-enemy hit scanner: one (laser, enemy) pair per clock.
// Optional score output enabled by defining MULTI_HIT_SCORE_EN.
module multi_hit_controller #(
  parameter int NUM_ENEMIES = 8,
  parameter int NUM_LASERS  = 2,
  parameter int COORD_W     = 10,
  parameter int ENEMY_SIZE  = 30,
  parameter int LASER_W     = 20,
  parameter int LASER_H     = 49
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_x,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_y,
  input  logic [NUM_ENEMIES-1:0]         enemy_alive,
  input  logic [NUM_LASERS*COORD_W-1:0]  laser_x,
  input  logic [NUM_LASERS*COORD_W-1:0]  laser_y,
  input  logic [NUM_LASERS-1:0]          laser_active,
  input  logic [NUM_ENEMIES-1:0]         enemy_clr,
  input  logic [NUM_LASERS-1:0]          laser_clr,
  output logic [NUM_ENEMIES-1:0]         enemy_hit,
  output logic [NUM_LASERS-1:0]          laser_hit,
  output logic                           scan_busy,
  output logic                           scan_done,
`ifdef MULTI_HIT_SCORE_EN
  input  logic                           score_clr,
  output logic [15:0]                    score,
`endif
  output logic [$clog2(NUM_ENEMIES+1)-1:0] hits_this_frame
);

  localparam int EIW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int LIW = (NUM_LASERS > 1) ? $clog2(NUM_LASERS) : 1;
  localparam int HW  = $clog2(NUM_ENEMIES + 1);
  localparam int CW1 = COORD_W + 1;

  localparam logic [EIW-1:0] E_LAST  = EIW'(NUM_ENEMIES - 1);
  localparam logic [LIW-1:0] L_LAST  = LIW'(NUM_LASERS - 1);
  localparam logic [HW-1:0]  ACC_MAX = HW'(NUM_ENEMIES);
  localparam logic [CW1-1:0] ES      = CW1'(ENEMY_SIZE);
  localparam logic [CW1-1:0] LW      = CW1'(LASER_W);
  localparam logic [CW1-1:0] LH      = CW1'(LASER_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [COORD_W-1:0]     r_ex [NUM_ENEMIES];
  logic [COORD_W-1:0]     r_ey [NUM_ENEMIES];
  logic [COORD_W-1:0]     r_lx [NUM_LASERS];
  logic [COORD_W-1:0]     r_ly [NUM_LASERS];
  logic [NUM_ENEMIES-1:0] r_ealive;
  logic [NUM_LASERS-1:0]  r_lact;
  logic [EIW-1:0]         r_ei;
  logic [LIW-1:0]         r_li;
  logic [HW-1:0]          r_acc;

  logic [CW1-1:0]         w_ex;
  logic [CW1-1:0]         w_ey;
  logic [CW1-1:0]         w_lx;
  logic [CW1-1:0]         w_ly;
  logic                   w_ovl;
  logic                   w_hit;
  logic                   w_last;
  logic [NUM_ENEMIES-1:0] w_ehit_n;
  logic [NUM_LASERS-1:0]  w_lhit_n;

  // Widen before adding so boxes near the screen edge never wrap.
  assign w_ex = {1'b0, r_ex[r_ei]};
  assign w_ey = {1'b0, r_ey[r_ei]};
  assign w_lx = {1'b0, r_lx[r_li]};
  assign w_ly = {1'b0, r_ly[r_li]};

  assign w_ovl = (w_lx <= w_ex + ES) &&
                 (w_lx + LW >= w_ex) &&
                 (w_ly <= w_ey + ES) &&
                 (w_ly + LH >= w_ey);

  assign w_hit = (r_state == S_SCAN) &&
                 r_lact[r_li] && r_ealive[r_ei] &&
                 !laser_hit[r_li] && !enemy_hit[r_ei] &&
                 w_ovl;

  assign w_last = (r_li == L_LAST) && (r_ei == E_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    scan_busy = 1'b0;
    scan_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_n = S_SCAN;
      end
      S_SCAN: begin
        scan_busy = 1'b1;
        if (w_last) w_state_n = S_DONE;
      end
      S_DONE: begin
        scan_done = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // A set on the same bit as a clear takes priority.
  always_comb begin
    w_ehit_n = enemy_hit & ~enemy_clr;
    w_lhit_n = laser_hit & ~laser_clr;
    if (w_hit) begin
      w_ehit_n[r_ei] = 1'b1;
      w_lhit_n[r_li] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      enemy_hit       <= '0;
      laser_hit       <= '0;
      hits_this_frame <= '0;
      r_ealive        <= '0;
      r_lact          <= '0;
      r_ei            <= '0;
      r_li            <= '0;
      r_acc           <= '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        r_ex[i] <= '0;
        r_ey[i] <= '0;
      end
      for (int i = 0; i < NUM_LASERS; i++) begin
        r_lx[i] <= '0;
        r_ly[i] <= '0;
      end
    end else begin
      enemy_hit <= w_ehit_n;
      laser_hit <= w_lhit_n;
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
              r_ex[i] <= enemy_x[i*COORD_W +: COORD_W];
              r_ey[i] <= enemy_y[i*COORD_W +: COORD_W];
            end
            for (int i = 0; i < NUM_LASERS; i++) begin
              r_lx[i] <= laser_x[i*COORD_W +: COORD_W];
              r_ly[i] <= laser_y[i*COORD_W +: COORD_W];
            end
            r_ealive <= enemy_alive;
            r_lact   <= laser_active;
            r_ei     <= '0;
            r_li     <= '0;
            r_acc    <= '0;
          end
        end
        S_SCAN: begin
          if (w_hit && (r_acc != ACC_MAX)) r_acc <= r_acc + 1'b1;
          if (r_ei == E_LAST) begin
            r_ei <= '0;
            r_li <= r_li + 1'b1;
          end else begin
            r_ei <= r_ei + 1'b1;
          end
        end
        S_DONE: begin
          hits_this_frame <= r_acc;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_HIT_SCORE_EN
  logic [15:0] w_score_base;
  logic [15:0] w_score_n;

  // Clear first, then the hit bonus, so clear+hit leaves exactly one bonus.
  always_comb begin
    w_score_base = score_clr ? 16'd0 : score;
    w_score_n    = w_score_base;
    if (w_hit) begin
      if (w_score_base > 16'hFFF5) w_score_n = 16'hFFFF;
      else                         w_score_n = w_score_base + 16'd10;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) score <= '0;
    else          score <= w_score_n;
  end
`endif

endmodule
